// File: rtl/instruction_fetch_pkg.sv
// Shared constants, FSM state encoding and IF/ID entry layout for the fetch stage.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'b00,
    ST_REQ        = 2'b01,
    ST_WAIT       = 2'b10,
    ST_HALT       = 2'b11
  } fetch_state_e;

  // One fetched instruction together with its address (96 bits).
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;

  // No compressed instructions, so any nonzero low bit is a fault.
  function automatic logic is_misaligned(input logic [63:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a response that arrives while decode is stalled.
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  ifid_entry_t data_i,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  output logic        full_o,
  output ifid_entry_t data_o
);

  logic        full_q;
  ifid_entry_t data_q;

  // Occupancy flag and payload; clear wins over load, load wins over unload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (clear_i)       full_q <= 1'b0;
      else if (load_i)   full_q <= 1'b1;
      else if (unload_i) full_q <= 1'b0;
      if (load_i && !clear_i) data_q <= data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction memory requests, IF/ID register,
// skid buffer for stalls, redirect with response dropping, misaligned halt.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        imem_req_out,
  output logic [63:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [63:0] redirect_pc_in,
  output logic [31:0] instr_out,
  output logic [63:0] pc_out,
  output logic        valid_out,
  output logic        misaligned_out
);

  fetch_state_e state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic         drop_q, drop_d;
  ifid_entry_t  ifid_q, ifid_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         misaligned_q, misaligned_d;

  logic         skid_load, skid_unload, skid_clear, skid_full;
  ifid_entry_t  skid_data, resp_entry;
  logic         handshake, resp;

  fetch_skid_buffer u_skid (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .data_i   (resp_entry),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .full_o   (skid_full),
    .data_o   (skid_data)
  );

  // State and IF/ID registers; reset forces every output to its idle value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_RESET_WAIT;
      fetch_pc_q   <= RESET_VECTOR;
      drop_q       <= 1'b0;
      ifid_q       <= '{pc: 64'd0, instr: NOP_INSTR};
      ifid_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_q       <= drop_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Next-state, request handshake and IF/ID / skid steering.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_d       = drop_q;
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;
    misaligned_d = misaligned_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    // A full skid blocks new requests only while the stall persists: on the
    // release edge the skid drains into IF/ID and a request can go out.
    imem_req_out = (state_q == ST_REQ) && (!skid_full || !stall_in);
    handshake    = imem_req_out && imem_ready_in;
    resp         = (state_q == ST_WAIT) && imem_rvalid_in;
    // fetch_pc only moves on a response or redirect, so it is the response's PC.
    resp_entry   = '{pc: fetch_pc_q, instr: imem_rdata_in};

    if (redirect_in && state_q != ST_HALT) begin
      ifid_valid_d = 1'b0;
      ifid_d.instr = NOP_INSTR;
      skid_clear   = 1'b1;
      if (is_misaligned(redirect_pc_in)) begin
        state_d      = ST_HALT;
        misaligned_d = 1'b1;
        drop_d       = 1'b0;
      end else begin
        fetch_pc_d = redirect_pc_in;
        // Keep waiting for a still-outstanding (or just-accepted) request
        // so its stale response can be swallowed before refetching.
        if ((state_q == ST_WAIT && !imem_rvalid_in) || handshake) begin
          state_d = ST_WAIT;
          drop_d  = 1'b1;
        end else begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
        end
      end
    end else begin
      case (state_q)
        ST_RESET_WAIT: state_d = ST_REQ;
        ST_REQ:        if (handshake) state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid_in) begin
            state_d = ST_REQ;
            if (drop_q) drop_d = 1'b0;
            else        fetch_pc_d = fetch_pc_q + 64'd4;
          end
        end
        default: state_d = state_q;
      endcase

      if (skid_full && !stall_in) begin
        ifid_d       = skid_data;
        ifid_valid_d = 1'b1;
        skid_unload  = 1'b1;
      end else if (resp && !drop_q) begin
        if (ifid_valid_q && stall_in) begin
          skid_load = 1'b1;
        end else begin
          ifid_d       = resp_entry;
          ifid_valid_d = 1'b1;
        end
      end else if (!stall_in) begin
        ifid_valid_d = 1'b0;
        ifid_d.instr = NOP_INSTR;
      end
    end
  end

  assign imem_addr_out  = {fetch_pc_q[63:2], 2'b00};
  assign instr_out      = ifid_q.instr;
  assign pc_out         = ifid_q.pc;
  assign valid_out      = ifid_valid_q;
  assign misaligned_out = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table, hand-written reset/wrap
// sequences, then random traffic against a program-order stream model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113, I2 = 32'h0030_0193;
  localparam logic [31:0] I3 = 32'h0040_0213, I4 = 32'h0050_0293, I5 = 32'h0060_0313;
  localparam logic [31:0] I6 = 32'h0070_0393;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        imem_req_out;
  logic [63:0] imem_addr_out;
  logic        imem_ready_in, imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        stall_in, redirect_in;
  logic [63:0] redirect_pc_in;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic        valid_out, misaligned_out;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .imem_ready_in  (imem_ready_in),
    .imem_rvalid_in (imem_rvalid_in),
    .imem_rdata_in  (imem_rdata_in),
    .stall_in       (stall_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .misaligned_out (misaligned_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        stall, redir;
    logic [63:0] rpc;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic st, input logic rdr, input logic [63:0] rpc,
                              input logic ereq, input logic [63:0] eaddr, input logic ev,
                              input logic [63:0] epc, input logic [31:0] ei, input logic em);
    vec_t v;
    v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redir = rdr; v.rpc = rpc;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev; v.exp_pc = epc;
    v.exp_instr = ei; v.exp_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdr, input logic [63:0] rpc);
    imem_ready_in = rdy; imem_rvalid_in = rv; imem_rdata_in = rd;
    stall_in = st; redirect_in = rdr; redirect_pc_in = rpc;
  endtask

  // Reset held over two edges, released on a falling edge.
  task automatic do_reset();
    drive(0, 0, 32'h0, 0, 0, 64'h0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_req", {63'd0, imem_req_out}, 64'd0);
    check("rst_instr", {32'd0, instr_out}, {32'd0, NOP});
    check("rst_pc", pc_out, 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // ready rv rdata stall redir rpc | req addr valid pc instr mis
    vecs.push_back(mk(1,1,32'hDEAD_BEEF,0,0,0,   0,0,       0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,               1,0,       0,0,       NOP,0));
    vecs.push_back(mk(0,1,I0,0,0,0,              0,0,       0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,               1,4,       1,0,       I0,0));
    vecs.push_back(mk(0,1,I1,0,0,0,              0,0,       0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,               1,8,       1,4,       I1,0));
    vecs.push_back(mk(0,1,I2,0,0,0,              0,0,       0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,1,0,0,               1,12,      1,8,       I2,0));
    vecs.push_back(mk(0,1,I3,1,0,0,              0,0,       1,8,       I2,0));
    vecs.push_back(mk(1,0,0,1,0,0,               0,0,       1,8,       I2,0));
    vecs.push_back(mk(1,0,0,1,0,0,               0,0,       1,8,       I2,0));
    vecs.push_back(mk(0,0,0,0,0,0,               1,16,      1,8,       I2,0));
    vecs.push_back(mk(1,0,0,0,0,0,               1,16,      1,12,      I3,0));
    vecs.push_back(mk(0,1,I4,0,0,0,              0,0,       0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,               1,20,      1,16,      I4,0));
    vecs.push_back(mk(0,0,0,0,1,64'h100,         0,0,       0,0,       NOP,0));
    vecs.push_back(mk(0,1,32'hBAD0_0001,0,0,0,   0,0,       0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,               1,64'h100, 0,0,       NOP,0));
    vecs.push_back(mk(0,1,I5,0,0,0,              0,0,       0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,1,0,0,               1,64'h104, 1,64'h100, I5,0));
    vecs.push_back(mk(0,1,32'hBAD0_0002,1,1,64'h200, 0,0,   1,64'h100, I5,0));
    vecs.push_back(mk(0,0,0,1,0,0,               1,64'h200, 0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,               1,64'h200, 0,0,       NOP,0));
    vecs.push_back(mk(0,1,I6,0,0,0,              0,0,       0,0,       NOP,0));
    vecs.push_back(mk(0,0,0,0,0,0,               1,64'h204, 1,64'h200, I6,0));
    vecs.push_back(mk(0,0,0,0,1,64'h102,         1,64'h204, 0,0,       NOP,0));
    vecs.push_back(mk(1,0,0,0,0,0,               0,0,       0,0,       NOP,1));
    vecs.push_back(mk(1,1,32'hBAD0_0003,0,0,0,   0,0,       0,0,       NOP,1));

    // Directed table: row i's inputs are present during cycle i, outputs sampled before its edge.
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ready, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      #1;
      check($sformatf("row%0d_req", i), {63'd0, imem_req_out}, {63'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) check($sformatf("row%0d_addr", i), imem_addr_out, vecs[i].exp_addr);
      check($sformatf("row%0d_valid", i), {63'd0, valid_out}, {63'd0, vecs[i].exp_valid});
      check($sformatf("row%0d_instr", i), {32'd0, instr_out}, {32'd0, vecs[i].exp_instr});
      if (vecs[i].exp_valid || i == 0) check($sformatf("row%0d_pc", i), pc_out, vecs[i].exp_pc);
      check($sformatf("row%0d_mis", i), {63'd0, misaligned_out}, {63'd0, vecs[i].exp_mis});
      @(negedge clk_in);
    end

    // Asynchronous reset out of HALT, between clock edges.
    drive(0, 0, 32'h0, 0, 0, 64'h0);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_mis", {63'd0, misaligned_out}, 64'd0);
    check("async_rst_req", {63'd0, imem_req_out}, 64'd0);
    check("async_rst_valid", {63'd0, valid_out}, 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    // First cycle after reset ignores rvalid; then fetch restarts at RESET_VECTOR.
    drive(1, 1, 32'h1234_5678, 0, 0, 64'h0);
    #1;
    check("post_rst_wait_req", {63'd0, imem_req_out}, 64'd0);
    @(negedge clk_in);
    // Redirect (no handshake) to the top of the address space.
    drive(0, 0, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    #1;
    check("post_rst_req", {63'd0, imem_req_out}, 64'd1);
    check("post_rst_addr", imem_addr_out, 64'd0);
    check("post_rst_valid", {63'd0, valid_out}, 64'd0);
    @(negedge clk_in);
    drive(1, 0, 32'h0, 0, 0, 64'h0);
    #1;
    check("wrap_top_addr", imem_addr_out, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk_in);
    drive(0, 1, 32'h0BAD_F00D, 0, 0, 64'h0);
    #1;
    check("wrap_wait_req", {63'd0, imem_req_out}, 64'd0);
    @(negedge clk_in);
    drive(0, 0, 32'h0, 0, 0, 64'h0);
    #1;
    check("wrap_next_req", {63'd0, imem_req_out}, 64'd1);
    check("wrap_next_addr", imem_addr_out, 64'd0);
    check("wrap_valid", {63'd0, valid_out}, 64'd1);
    check("wrap_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", {32'd0, instr_out}, {32'd0, 32'h0BAD_F00D});
    @(negedge clk_in);

    // Random traffic: decode must see exactly the program-order stream,
    // restarting at each redirect target.
    begin
      logic        pending;
      logic [63:0] pend_addr;
      int          delay;
      logic [63:0] exp_pc;
      int          consumed;
      int          idle;
      logic        rv;
      logic [63:0] tgt;
      do_reset();
      pending = 1'b0; pend_addr = '0; delay = 0;
      exp_pc = 64'd0; consumed = 0; idle = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        rv  = pending && (delay == 0);
        tgt = {32'd0, $urandom} & ~64'h3;
        drive(($urandom_range(0, 9) < 6), rv, rv ? mem_word(pend_addr) : $urandom,
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0), tgt);
        #1;
        check("one_outstanding", {63'd0, imem_req_out && pending}, 64'd0);
        if (imem_req_out) check("addr_aligned", {62'd0, imem_addr_out[1:0]}, 64'd0);
        if (redirect_in) begin
          exp_pc = tgt;
          idle = 0;
        end else if (valid_out && !stall_in) begin
          check("stream_pc", pc_out, exp_pc);
          check("stream_instr", {32'd0, instr_out}, {32'd0, mem_word(exp_pc)});
          exp_pc = exp_pc + 64'd4;
          consumed++;
          idle = 0;
        end else begin
          idle++;
        end
        if (idle > 200) begin
          check("stream_progress_timeout", idle, 0);
          break;
        end
        if (rv) pending = 1'b0;
        if (imem_req_out && imem_ready_in) begin
          pending   = 1'b1;
          pend_addr = imem_addr_out;
          delay     = $urandom_range(0, 2);
        end else if (pending && delay > 0) begin
          delay--;
        end
        @(negedge clk_in);
      end
      check("stream_consumed_enough", {63'd0, consumed > 100}, 64'd1);
      check("stream_no_misaligned", {63'd0, misaligned_out}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
